// File: rtl/gpu_alu_pkg.sv
// Shared GPU ALU types: divider FSM state encoding and counter sizing helper.
package gpu_alu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_DONE
  } div_state_t;

  // One extra bit so the counter can reach WIDTH itself (the fixup cycle).
  function automatic int div_cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_seq_sub_borrow.sv
// Ripple borrow-chain subtractor: out = a - b, bout set when a < b.
module sub_borrow #(
  parameter int WIDTH = 33
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             bout
);

  always_comb begin
    logic br;
    br   = 1'b0;
    out  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out[i] = a[i] ^ b[i] ^ br;
      br     = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider, one quotient bit per cycle, fixed WIDTH+1 latency.
// Optional signed mode behind macro DIV_SIGNED_EN (adds is_signed port).
module div_seq
  import gpu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_END = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d;
  logic [WIDTH-1:0] res_rem_q, res_rem_d;
  logic             res_dbz_q, res_dbz_d;
`ifdef DIV_SIGNED_EN
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
`endif

  logic [WIDTH:0]   trial_a, trial_b, trial_diff;
  logic             trial_bout;
  logic             take;

  // quo_q shifts dividend bits out of its MSB while quotient bits enter at the LSB.
  assign trial_a = {rem_q, quo_q[WIDTH-1]};
  assign trial_b = {1'b0, dvsr_q};

  sub_borrow #(.WIDTH(WIDTH + 1)) u_sub (
    .a    (trial_a),
    .b    (trial_b),
    .out  (trial_diff),
    .bout (trial_bout)
  );

  // The difference MSB is always clear when there is no borrow; folding it in is free.
  assign take = ~trial_bout & ~trial_diff[WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    res_dbz_d = res_dbz_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
`ifdef DIV_SIGNED_EN
          neg_rem_d = is_signed & dividend[WIDTH-1];
          neg_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          quo_d     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dvsr_d    = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
`else
          quo_d   = dividend;
          dvsr_d  = divisor;
`endif
        end
      end
      DIV_BUSY: begin
        if (cnt_q != CNT_END) begin
          rem_d = take ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], take};
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          state_d   = DIV_DONE;
          res_dbz_d = (dvsr_q == '0);
          res_quo_d = quo_q;
          res_rem_d = rem_q;
`ifdef DIV_SIGNED_EN
          // Divide-by-zero keeps the all-ones quotient; remainder negation restores dividend.
          if (neg_quo_q && (dvsr_q != '0)) res_quo_d = -quo_q;
          if (neg_rem_q) res_rem_d = -rem_q;
`endif
        end
      end
      DIV_DONE: begin
        if (out_ready) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      res_dbz_q <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      res_dbz_q <= res_dbz_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign in_ready    = (state_q == DIV_IDLE);
  assign out_valid   = (state_q == DIV_DONE);
  assign quotient    = res_quo_q;
  assign remainder   = res_rem_q;
  assign div_by_zero = res_dbz_q;

endmodule
